hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Hazard detection and forwarding control for the 5-stage in-order RISC-V integer pipeline (F/D/E/M/W).
- Per cycle, it produces these controls:
  - ALU operand forwarding selects for the Execute stage.
  - Fetch/Decode stall for load-use hazards.
  - Decode/Execute flush for taken branches/jumps and load-use bubbles.
- Hazard controls are purely combinational.
- A small clocked block keeps stall/flush event counters for performance monitoring.

Parameters:
- REG_AW, 5, register-index width (32 architectural registers).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock; counters update on rising edge.
- reset  input  1  synchronous, active-high; clears counters only.
- rs1d  input  REG_AW  source register 1 of instruction in Decode.
- rs2d  input  REG_AW  source register 2 of instruction in Decode.
- rs1e  input  REG_AW  source register 1 of instruction in Execute.
- rs2e  input  REG_AW  source register 2 of instruction in Execute.
- rde  input  REG_AW  destination register in Execute.
- rdm  input  REG_AW  destination register in Memory.
- rdw  input  REG_AW  destination register in Writeback.
- regwritem  input  1  Memory-stage instruction writes the register file.
- regwritew  input  1  Writeback-stage instruction writes the register file.
- resultsrce0  input  1  bit 0 of Execute resultsrc; 1 = instruction in Execute is a load.
- pcsrce  input  1  taken branch/jump resolved in Execute.
- forwardae  output  2  ALU operand A select: 00 register file, 01 Writeback result, 10 Memory ALU result.
- forwardbe  output  2  ALU operand B select, same encoding.
- stallf  output  1  hold the PC register.
- stalld  output  1  hold the F/D pipeline register.
- flushd  output  1  clear the F/D pipeline register.
- flushe  output  1  clear the D/E pipeline register.
- stallcnt  output  CNT_W  count of cycles with stalld=1.
- flushcnt  output  CNT_W  count of cycles with flushd=1.

Behaviour:
- All hazard outputs are combinational functions of the current inputs. They are valid within the same cycle, have no latency, and are not affected by reset.
- forwardae:
  - 10 if rs1e==rdm, regwritem=1 and rs1e!=0.
  - Otherwise 01 if rs1e==rdw, regwritew=1 and rs1e!=0.
  - Otherwise 00.
  - Memory takes priority over Writeback when both match.
  - 11 is never produced.
- forwardbe: identical rule, using rs2e.
- Register x0 never forwards, even if a write to x0 is flagged.
- lwstall = resultsrce0 AND rde!=0 AND (rs1d==rde OR rs2d==rde).
- stallf = stalld = lwstall.
- flushd = pcsrce.
- flushe = lwstall OR pcsrce.
- If lwstall and pcsrce are both asserted, all four outputs stallf, stalld, flushd and flushe are 1. Flush wins at the F/D register; the pipeline registers apply the priority.
- Counters:
  - On a rising clk edge with reset=1, stallcnt and flushcnt go to 0.
  - Otherwise stallcnt increments by 1 when stalld=1, and flushcnt increments by 1 when flushd=1.
  - Both may increment in the same cycle.
  - At the all-ones value, behaviour is set by the optional feature.
- Reset values: stallcnt=0, flushcnt=0. Hazard outputs are combinational and have no reset value.
- Reset asserted mid-operation clears only the counters; forwarding, stall and flush signals remain live.

Optional Feature:
- Macro HAZARD_CNT_SAT_EN.
- Defined: each counter saturates at 2^CNT_W-1 and holds there until reset.
- Undefined: each counter wraps modulo 2^CNT_W, so all-ones + 1 becomes 0.
- Hazard logic is identical in both builds.

Decomposition:
- Shared package (e.g. hazard_pkg) holds:
  - Forwarding-select constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_AW default.
  - ZERO_REG=0.
- One natural sub-module: hazard_fwd_sel. It is instantiated twice (operands A and B) and computes one forward select from rsXe/rdm/rdw/regwritem/regwritew.
- Counters stay in the top module.

Test Plan:
- No hazard: rs1e=1, rs2e=2, rdm=rdw=0, rs1d=rs2d=rde=0, all enables 0 -> forwardae=00, forwardbe=00, stallf=stalld=flushd=flushe=0.
- Memory forward: then rs1e=5, rdm=5, regwritem=1 -> forwardae=10, forwardbe=00, no stall/flush.
- Writeback forward, plus priority and x0:
  - Then rs2e=6, rdw=6, regwritew=1 -> forwardae=10, forwardbe=01.
  - rs1e=rdm=rdw=3 with both writes set -> forwardae=10.
  - rs1e=rdm=0, regwritem=1 -> forwardae=00.
- Load-use: then rs1d=7, rs2d=0, rde=7, resultsrce0=1 -> stalld=stallf=1, flushe=1, flushd=0. Same stimulus with rde=0 and rs1d=0 -> no stall.
- Branch taken: then pcsrce=1, resultsrce0=0 -> stalld=stallf=0, flushd=1, flushe=1. Adding resultsrce0=1 -> all four outputs 1.
- Counters:
  - Reset, then 3 load-use cycles and 2 branch cycles -> stallcnt=3, flushcnt=2.
  - Reset mid-run clears both to 0 on the next edge.
  - With CNT_W=4, 17 stall cycles -> stallcnt=15 with HAZARD_CNT_SAT_EN, 1 without.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: forwarding-select encodings and register-index defaults shared by the hazard unit
package hazard_unit_pkg;
  localparam int REG_AW_DEF = 5;
  localparam int ZERO_REG = 0;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// hazard_fwd_sel: one Execute operand forward select (rs, rdm/rdw, regwritem/regwritew in; fwd out), Memory over Writeback, x0 never forwards
module hazard_fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rdm,
  input  logic [REG_AW-1:0] rdw,
  input  logic              regwritem,
  input  logic              regwritew,
  output logic [1:0]        fwd
);
  logic nz;
  always_comb begin
    nz = rs != REG_AW'(ZERO_REG);
    fwd = (nz && regwritem && rs == rdm) ? FWD_MEM :
          (nz && regwritew && rs == rdw) ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: combinational forward/stall/flush control for the F/D/E/M/W pipeline plus stall/flush event counters (reset clears counters only; HAZARD_CNT_SAT_EN makes counters saturate instead of wrap)
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1d,
  input  logic [REG_AW-1:0] rs2d,
  input  logic [REG_AW-1:0] rs1e,
  input  logic [REG_AW-1:0] rs2e,
  input  logic [REG_AW-1:0] rde,
  input  logic [REG_AW-1:0] rdm,
  input  logic [REG_AW-1:0] rdw,
  input  logic              regwritem,
  input  logic              regwritew,
  input  logic              resultsrce0,
  input  logic              pcsrce,
  output logic [1:0]        forwardae,
  output logic [1:0]        forwardbe,
  output logic              stallf,
  output logic              stalld,
  output logic              flushd,
  output logic              flushe,
  output logic [CNT_W-1:0]  stallcnt,
  output logic [CNT_W-1:0]  flushcnt
);
`ifdef HAZARD_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic lwstall;
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(rs1e), .rdm(rdm), .rdw(rdw), .regwritem(regwritem), .regwritew(regwritew), .fwd(forwardae)
  );
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(rs2e), .rdm(rdm), .rdw(rdw), .regwritem(regwritem), .regwritew(regwritew), .fwd(forwardbe)
  );
  always_comb begin
    lwstall = resultsrce0 && rde != REG_AW'(ZERO_REG) && (rs1d == rde || rs2d == rde);
    stallf = lwstall;
    stalld = lwstall;
    flushd = pcsrce;
    flushe = lwstall || pcsrce;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stallcnt <= '0;
      flushcnt <= '0;
    end else begin
      if (stalld && !(SAT && &stallcnt)) stallcnt <= stallcnt + CNT_W'(1);
      if (flushd && !(SAT && &flushcnt)) flushcnt <= flushcnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven checks of hazard controls plus counter sequences on a 4-bit-counter hazard_unit
module tb_hazard_unit;
  localparam int CW = 4;
  logic clk = 0, reset;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic regwritem, regwritew, resultsrce0, pcsrce;
  logic [1:0] forwardae, forwardbe;
  logic stallf, stalld, flushd, flushe;
  logic [CW-1:0] stallcnt, flushcnt;
  int errors = 0, checks = 0;
  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic rwm, rww, ld, pc;
    logic [1:0] fa, fb;
    logic st, fd, fe;
  } vec_t;
  vec_t vecs[15];
  hazard_unit #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
    .rde(rde), .rdm(rdm), .rdw(rdw), .regwritem(regwritem), .regwritew(regwritew),
    .resultsrce0(resultsrce0), .pcsrce(pcsrce), .forwardae(forwardae), .forwardbe(forwardbe),
    .stallf(stallf), .stalld(stalld), .flushd(flushd), .flushe(flushe),
    .stallcnt(stallcnt), .flushcnt(flushcnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic drive(input vec_t v);
    rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e; rde = v.rde; rdm = v.rdm; rdw = v.rdw;
    regwritem = v.rwm; regwritew = v.rww; resultsrce0 = v.ld; pcsrce = v.pc;
  endtask
  task automatic chk_vec(input string n, input vec_t v);
    chk({n, ".fa"}, 32'(forwardae), 32'(v.fa));
    chk({n, ".fb"}, 32'(forwardbe), 32'(v.fb));
    chk({n, ".stallf"}, 32'(stallf), 32'(v.st));
    chk({n, ".stalld"}, 32'(stalld), 32'(v.st));
    chk({n, ".flushd"}, 32'(flushd), 32'(v.fd));
    chk({n, ".flushe"}, 32'(flushe), 32'(v.fe));
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t idle, lu, br;
    int exp_sat;
    //           rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld pc  fa     fb     st fd fe
    vecs[0]  = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[1]  = '{0, 0, 5, 2, 0, 5, 0, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0};
    vecs[2]  = '{0, 0, 5, 6, 0, 5, 6, 1, 1, 0, 0, 2'b10, 2'b01, 0, 0, 0};
    vecs[3]  = '{0, 0, 3, 6, 0, 3, 3, 1, 1, 0, 0, 2'b10, 2'b00, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 2, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[5]  = '{0, 0, 4, 2, 0, 9, 4, 1, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0};
    vecs[6]  = '{0, 0, 4, 4, 0, 4, 4, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[7]  = '{7, 0, 1, 2, 7, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1};
    vecs[8]  = '{1, 7, 1, 2, 7, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1};
    vecs[9]  = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[10] = '{7, 0, 1, 2, 7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[11] = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1};
    vecs[12] = '{7, 0, 1, 2, 7, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 1, 1};
    vecs[13] = '{0, 0, 1, 8, 0, 8, 8, 1, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0};
    vecs[14] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    idle = vecs[0];
    lu = vecs[7];
    br = vecs[11];
    reset = 1;
    drive(idle);
    cyc();
    chk("rst.stallcnt", 32'(stallcnt), 0);
    chk("rst.flushcnt", 32'(flushcnt), 0);
    reset = 0;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      #1;
      chk_vec($sformatf("vec%0d", i), vecs[i]);
      #2;
    end
    reset = 1;
    drive(idle);
    cyc();
    reset = 0;
    chk("clr.stallcnt", 32'(stallcnt), 0);
    chk("clr.flushcnt", 32'(flushcnt), 0);
    drive(lu);
    repeat (3) cyc();
    drive(br);
    repeat (2) cyc();
    drive(idle);
    cyc();
    chk("seq.stallcnt", 32'(stallcnt), 3);
    chk("seq.flushcnt", 32'(flushcnt), 2);
    drive(vecs[12]);
    cyc();
    chk("both.stallcnt", 32'(stallcnt), 4);
    chk("both.flushcnt", 32'(flushcnt), 3);
    reset = 1;
    #1;
    chk_vec("live_in_reset", vecs[12]);
    cyc();
    chk("midrst.stallcnt", 32'(stallcnt), 0);
    chk("midrst.flushcnt", 32'(flushcnt), 0);
    reset = 0;
    repeat (17) cyc();
`ifdef HAZARD_CNT_SAT_EN
    exp_sat = 15;
`else
    exp_sat = 1;
`endif
    chk("ovf.stallcnt", 32'(stallcnt), 32'(exp_sat));
    chk("ovf.flushcnt", 32'(flushcnt), 32'(exp_sat));
    drive(idle);
    cyc();
    chk("hold.stallcnt", 32'(stallcnt), 32'(exp_sat));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
